mult_div_unit: RTL
==================

# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS datapath. It consumes the two register-file read operands (rs and rt) for MULT/MULTU/DIV/DIVU and holds the result in HI/LO. The write-back mux forwards HI/LO (MFHI/MFLO) into the register file write-data path. While an operation is in flight, `Busy` stalls the PC and instruction fetch.

## Interface
- No parameters; width is fixed at 32 bits.
- `CLK` input 1: rising-edge clock, shared with the register file.
- `RESET_N` input 1: asynchronous, active-low reset.
- `Start` input 1: launch an operation; sampled only in IDLE.
- `Op` input 2: operation select. 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `Operand_A` input 32: rs value, the multiplicand or dividend.
- `Operand_B` input 32: rt value, the multiplier or divisor.
- `Write_HI` input 1: MTHI strobe.
- `Write_LO` input 1: MTLO strobe.
- `Write_Data` input 32: data for MTHI/MTLO (rs value).
- `Busy` output 1: high while an operation is in flight.
- `Done` output 1: one-cycle completion pulse.
- `Div_by_zero` output 1: one-cycle pulse coincident with `Done` when a divide had `Operand_B == 0`.
- `HI` output 32: HI register. Holds the product upper word or the remainder.
- `LO` output 32: LO register. Holds the product lower word or the quotient.

## Operation
- **Reset.** `RESET_N` low clears everything: `HI = LO = 0`, `Busy = Done = Div_by_zero = 0`, FSM to IDLE. Reset takes effect immediately and aborts any operation in flight.
- **FSM states:** IDLE, RUN, FIX.
- **IDLE → RUN** when `Start = 1`.
  - Operands, `Op` and a 6-bit iteration counter are latched; the counter is set to 32.
  - Signed ops (01, 11) latch absolute values. They also latch the result signs: product/quotient sign = A[31]^B[31]; remainder sign = A[31].
- **RUN** performs one iteration per cycle and decrements the counter; at 0 it moves to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 1 quotient bit per cycle.
- **FIX → IDLE**, a single cycle that writes the results:
  - Multiply: HI/LO = the 64-bit product, negated in two's complement if signed and the sign bit is set.
  - Divide: LO = quotient and HI = remainder, each negated independently per its latched sign.
  - `Done` pulses. `Div_by_zero` pulses if this was a divide with B == 0.
- **Divide by zero.**
  - Full latency is still taken, with no early exit.
  - Result is LO = 32'hFFFF_FFFF and HI = Operand_A as latched (the raw bits of A, not |A|).
  - Sign fix is skipped.
- **Signed corner case.** DIV of 32'h8000_0000 by 32'hFFFF_FFFF gives LO = 32'h8000_0000, HI = 0 (wraps, no trap).
- **MTHI/MTLO.**
  - In IDLE with `Start = 0`, `Write_HI`/`Write_LO` load `Write_Data` into HI/LO on the next edge. Both may assert together.
  - Ignored in RUN and FIX.
  - `Start` together with a write strobe in IDLE: `Start` wins and the write is dropped.
- **Start outside IDLE.** `Start` in RUN or FIX is ignored; the operation in flight is unaffected.
- **HI/LO stability.** HI/LO keep their previous values for the whole of RUN and update only at the FIX edge.

## Timing
- Start is accepted at edge E0. `Busy` is high from after E0 through the cycle before E33.
- RUN occupies edges E1..E32. FIX writes HI/LO at edge E33.
- `Done` and `Div_by_zero` are high for the single cycle after E33. HI/LO are valid in that same cycle. `Busy` is low in that cycle.
- Total latency is 33 cycles from Start to Done, for every Op.
- A new `Start` may be accepted at E33+1, i.e. in the `Done` cycle.
- All outputs are registered; none depends combinationally on the inputs.
- `RESET_N` assertion is asynchronous. Deassertion is sampled at the next `CLK` rise.

## Configuration
- `MULTDIV_SIGNED_EN` defined:
  - Op 01 and 11 are signed MULT/DIV.
  - Absolute-value and sign-fix logic is compiled in.
- `MULTDIV_SIGNED_EN` undefined:
  - Op[0] is ignored; MULT behaves as MULTU and DIV as DIVU.
  - Sign logic is removed.
  - Timing and all other behaviour are identical.

## Test plan
- Reset, then MULTU A = FFFF_FFFF, B = FFFF_FFFF → after 33 cycles HI = FFFF_FFFE, LO = 0000_0001. `Done` is a single-cycle pulse; `Busy` is high for exactly 33 cycles.
- MULT A = FFFF_FFFD (−3), B = 0000_0005 → HI = FFFF_FFFF, LO = FFFF_FFF1 with the macro defined. Without the macro: HI = 0000_0004, LO = FFFF_FFF1.
- DIV A = FFFF_FFF9 (−7), B = 0000_0002 → LO = FFFF_FFFD, HI = FFFF_FFFF. Then DIVU A = 0000_0064, B = 0 → LO = FFFF_FFFF, HI = 0000_0064, `Div_by_zero` pulses with `Done`.
- MTHI 1234_5678 and MTLO 9ABC_DEF0 in IDLE → HI/LO load next edge. Start MULTU 3×4, then pulse `Write_HI` and `Start` (new operands) at cycle 10 → both ignored. Final HI = 0, LO = 0000_000C.
- Start MULTU, drop `RESET_N` at cycle 15 → HI = LO = 0 and `Busy` = 0 immediately. No `Done` occurs. After release, a new MULTU 2×3 completes correctly with LO = 6.
- `Start` and `Write_LO` asserted together in IDLE → the operation runs and the LO write is dropped. Back-to-back Start in the `Done` cycle is accepted.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit multiply/divide with HI/LO registers, 33 cycles Start-to-Done.
// Define MULTDIV_SIGNED_EN to make Op[0] select signed MULT/DIV; otherwise every op is unsigned.
module mult_div_unit (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] Operand_A,
    input  logic [31:0] Operand_B,
    input  logic        Write_HI,
    input  logic        Write_LO,
    input  logic [31:0] Write_Data,
    output logic        Busy,
    output logic        Done,
    output logic        Div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned W     = 32;
    localparam int unsigned W2    = 2 * W;
    localparam int unsigned CNT_W = 6;
    localparam logic [CNT_W-1:0] ITERS = CNT_W'(W);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [W2-1:0]    acc, acc_nxt;
    logic [W-1:0]     mag, mag_nxt;
    logic [W-1:0]     a_raw, a_raw_nxt;
    logic             is_div, is_div_nxt;
    logic             dbz, dbz_nxt;
    logic [W-1:0]     hi_nxt, lo_nxt;
    logic             busy_nxt, done_nxt, dbz_out_nxt;

    // Operand magnitudes fed to the unsigned iteration datapath
    logic [W-1:0] a_abs, b_abs;

`ifdef MULTDIV_SIGNED_EN
    logic sgn_op;
    logic q_neg, q_neg_nxt;
    logic r_neg, r_neg_nxt;

    assign sgn_op = Op[0];
    assign a_abs  = (sgn_op && Operand_A[W-1]) ? W'(-Operand_A) : Operand_A;
    assign b_abs  = (sgn_op && Operand_B[W-1]) ? W'(-Operand_B) : Operand_B;
`else
    logic unused_op0;

    assign unused_op0 = Op[0];
    assign a_abs      = Operand_A;
    assign b_abs      = Operand_B;
`endif

    // One iteration of shift-add multiply and restoring divide
    logic [W:0] mul_sum, div_part, div_diff;
    logic       div_take;

    always_comb begin
        mul_sum  = {1'b0, acc[W2-1:W]} + (acc[0] ? {1'b0, mag} : {(W+1){1'b0}});
        div_part = acc[W2-1:W-1];
        div_diff = div_part - {1'b0, mag};
        div_take = (div_part >= {1'b0, mag});
    end

    // Final sign correction of the accumulated magnitudes
    logic [W2-1:0] prod_fix;
    logic [W-1:0]  quot_fix, rem_fix;

    always_comb begin
        prod_fix = acc;
        quot_fix = acc[W-1:0];
        rem_fix  = acc[W2-1:W];
`ifdef MULTDIV_SIGNED_EN
        if (q_neg) begin
            prod_fix = -acc;
            quot_fix = W'(-acc[W-1:0]);
        end
        if (r_neg) begin
            rem_fix = W'(-acc[W2-1:W]);
        end
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        acc_nxt     = acc;
        mag_nxt     = mag;
        a_raw_nxt   = a_raw;
        is_div_nxt  = is_div;
        dbz_nxt     = dbz;
        hi_nxt      = HI;
        lo_nxt      = LO;
        busy_nxt    = Busy;
        done_nxt    = 1'b0;
        dbz_out_nxt = 1'b0;
`ifdef MULTDIV_SIGNED_EN
        q_neg_nxt   = q_neg;
        r_neg_nxt   = r_neg;
`endif

        unique case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt  = RUN;
                    cnt_nxt    = ITERS;
                    is_div_nxt = Op[1];
                    a_raw_nxt  = Operand_A;
                    dbz_nxt    = Op[1] && (Operand_B == '0);
                    busy_nxt   = 1'b1;
                    if (Op[1]) begin
                        mag_nxt = b_abs;
                        acc_nxt = {{W{1'b0}}, a_abs};
                    end else begin
                        mag_nxt = a_abs;
                        acc_nxt = {{W{1'b0}}, b_abs};
                    end
`ifdef MULTDIV_SIGNED_EN
                    q_neg_nxt = sgn_op && (Operand_A[W-1] ^ Operand_B[W-1]);
                    r_neg_nxt = sgn_op && Operand_A[W-1];
`endif
                end else begin
                    if (Write_HI) begin
                        hi_nxt = Write_Data;
                    end
                    if (Write_LO) begin
                        lo_nxt = Write_Data;
                    end
                end
            end

            RUN: begin
                cnt_nxt = cnt - ONE;
                if (is_div) begin
                    acc_nxt = {(div_take ? div_diff[W-1:0] : div_part[W-1:0]),
                               acc[W-2:0], div_take};
                end else begin
                    acc_nxt = {mul_sum, acc[W-1:1]};
                end
                if (cnt == ONE) begin
                    state_nxt = FIX;
                end
            end

            FIX: begin
                state_nxt   = IDLE;
                busy_nxt    = 1'b0;
                done_nxt    = 1'b1;
                dbz_out_nxt = dbz;
                // Divide by zero reports the raw dividend with an all-ones quotient
                if (dbz) begin
                    hi_nxt = a_raw;
                    lo_nxt = '1;
                end else if (is_div) begin
                    hi_nxt = rem_fix;
                    lo_nxt = quot_fix;
                end else begin
                    hi_nxt = prod_fix[W2-1:W];
                    lo_nxt = prod_fix[W-1:0];
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mag         <= '0;
            a_raw       <= '0;
            is_div      <= 1'b0;
            dbz         <= 1'b0;
            HI          <= '0;
            LO          <= '0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Div_by_zero <= 1'b0;
`ifdef MULTDIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            acc         <= acc_nxt;
            mag         <= mag_nxt;
            a_raw       <= a_raw_nxt;
            is_div      <= is_div_nxt;
            dbz         <= dbz_nxt;
            HI          <= hi_nxt;
            LO          <= lo_nxt;
            Busy        <= busy_nxt;
            Done        <= done_nxt;
            Div_by_zero <= dbz_out_nxt;
`ifdef MULTDIV_SIGNED_EN
            q_neg       <= q_neg_nxt;
            r_neg       <= r_neg_nxt;
`endif
        end
    end

endmodule
